pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush/redirect sequencer for the 5-stage RV32 pipeline.
- Resolves four conditions into per-stage enable, hold, bubble and flush strobes: instruction-memory wait, data-memory wait, load-use hazard and taken branch/jump from EX.
- Drives the DM_busy-style hold input of the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Latches a redirect target when a branch resolves during an outstanding fetch.

Parameters:
- WAIT_MAX, 255, consecutive busy cycles (IM or DM) after which the bus_err watchdog fires; counter width = $clog2(WAIT_MAX+1).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- IM_busy  in  1  fetch outstanding; IF output invalid
- DM_busy  in  1  data access outstanding
- ID_rs1, ID_rs2  in  5  source registers of the instruction in ID
- ID_use_rs1, ID_use_rs2  in  1  instruction in ID reads rs1/rs2
- ID_EX_MemRead  in  1  instruction in EX is a load
- ID_EX_Rd  in  5  destination of the instruction in EX
- EX_br_taken  in  1  branch/jump taken in EX
- EX_br_target  in  32  resolved target
- PC_en  out  1  PC register update enable
- redirect_valid  out  1  PC loads redirect_pc this cycle
- redirect_pc  out  32  redirect target
- IF_ID_en  out  1  IF/ID load enable
- IF_ID_flush  out  1  IF/ID loads NOP
- ID_EX_bubble  out  1  ID/EX loads NOP controls (RegWrite/MemRead/MemWrite=0)
- pipe_hold  out  1  hold for ID/EX, EX/MEM, MEM/WB
- bus_err  out  1  sticky watchdog flag
- ctrl_state  out  2  current FSM state

Behaviour:
- FSM states: BOOT=0, RUN=1, IM_WAIT=2, DM_WAIT=3.
- Reset: state=BOOT, redir_pend=0, redir_reg=0, wait_cnt=0, bus_err=0.
- BOOT outputs: PC_en=0, IF_ID_en=0, IF_ID_flush=1, ID_EX_bubble=1, pipe_hold=0, redirect_valid=0, redirect_pc=0. BOOT moves to RUN unconditionally on the first clock after reset release.
- Priority, highest first: DM_busy > EX_br_taken > load-use > IM_busy.
- DM_busy=1 (state goes to or stays in DM_WAIT):
  - pipe_hold=1, PC_en=0, IF_ID_en=0, all flush/bubble=0.
  - EX_br_taken is ignored, because the EX stage is frozen.
- Load-use: ID_EX_MemRead & ID_EX_Rd!=0 & ((ID_use_rs1 & ID_rs1==ID_EX_Rd) | (ID_use_rs2 & ID_rs2==ID_EX_Rd)).
  - Response: PC_en=0, IF_ID_en=0, ID_EX_bubble=1.
  - Exactly one bubble per occurrence.
- EX_br_taken, not DM_busy:
  - IF_ID_flush=1 and ID_EX_bubble=1.
  - If IM_busy=0: PC_en=1, redirect_valid=1, redirect_pc=EX_br_target, same cycle.
  - If IM_busy=1: latch redir_reg=EX_br_target and set redir_pend=1; PC_en=0.
- IM_busy=1 alone (IM_WAIT): PC_en=0, IF_ID_flush=1 (NOP into ID), downstream runs.
- redir_pend=1 and IM_busy falls:
  - PC_en=1, redirect_valid=1, redirect_pc=redir_reg, IF_ID_flush=1 (returned wrong-path instruction discarded).
  - redir_pend clears on that edge.
  - A new EX_br_taken in the same cycle overrides with EX_br_target.
- Normal RUN: PC_en=1, IF_ID_en=1, all others 0, redirect_pc=redir_reg.
- Watchdog:
  - wait_cnt increments each cycle IM_busy|DM_busy is high, and clears when both are low.
  - At wait_cnt==WAIT_MAX, bus_err is set; it is sticky until reset and saturates.
  - Stall behaviour is unchanged.
- Reset mid-wait: everything returns to BOOT values immediately (asynchronous); any pending redirect is lost.

Optional Feature:
- Macro HAZ_PERF_EN.
- When defined, adds outputs perf_dm_stall, perf_im_stall, perf_lu_stall and perf_flush, 32 bits each, reset 0.
- Each counts the cycles its condition is the winning priority cause; perf_flush counts IF_ID_flush cycles caused by redirects.
- Counters wrap at 2^32.
- When not defined, these ports and counters are absent.

Test Plan:
- Reset low 3 cycles then release -> BOOT outputs for 1 cycle (PC_en=0, IF_ID_flush=1), then ctrl_state=1, PC_en=1, IF_ID_en=1.
- ID_EX_MemRead=1, ID_EX_Rd=5, ID_rs2=5, ID_use_rs2=1 -> one cycle PC_en=0, IF_ID_en=0, ID_EX_bubble=1; ID_EX_Rd=0 variant -> no stall.
- DM_busy high 4 cycles with EX_br_taken=1 and load-use active -> pipe_hold=1 for 4 cycles, no redirect and no bubble; the branch redirects on the cycle DM_busy falls.
- EX_br_taken=1, target 0x0000_0100, IM_busy=1 for 3 cycles -> redir_pend set, PC_en=0; on IM_busy fall, redirect_valid=1, redirect_pc=0x100, IF_ID_flush=1.
- Same as previous, with a second EX_br_taken to 0x200 on the release cycle -> redirect_pc=0x200.
- WAIT_MAX=8, IM_busy held 10 cycles -> bus_err rises after 8 busy cycles and stays 1 after IM_busy drops; HAZ_PERF_EN build -> perf_im_stall=10.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: signal bundle between the 5-stage pipeline (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if;
  logic        IM_busy;
  logic        DM_busy;
  logic [4:0]  ID_rs1;
  logic [4:0]  ID_rs2;
  logic        ID_use_rs1;
  logic        ID_use_rs2;
  logic        ID_EX_MemRead;
  logic [4:0]  ID_EX_Rd;
  logic        EX_br_taken;
  logic [31:0] EX_br_target;
  logic        PC_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        IF_ID_en;
  logic        IF_ID_flush;
  logic        ID_EX_bubble;
  logic        pipe_hold;
  logic        bus_err;
  logic [1:0]  ctrl_state;
  modport master (
    output IM_busy, DM_busy, ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, ID_EX_MemRead, ID_EX_Rd,
           EX_br_taken, EX_br_target,
    input  PC_en, redirect_valid, redirect_pc, IF_ID_en, IF_ID_flush, ID_EX_bubble, pipe_hold,
           bus_err, ctrl_state
  );
  modport slave (
    input  IM_busy, DM_busy, ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, ID_EX_MemRead, ID_EX_Rd,
           EX_br_taken, EX_br_target,
    output PC_en, redirect_valid, redirect_pc, IF_ID_en, IF_ID_flush, ID_EX_bubble, pipe_hold,
           bus_err, ctrl_state
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/redirect sequencer for the 5-stage RV32 pipeline.
// Optional HAZ_PERF_EN adds 32-bit stall/flush cause counters.
module pipe_hazard_ctrl #(
  parameter int WAIT_MAX = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_hazard_ctrl_if.slave bus
`ifdef HAZ_PERF_EN
  ,
  output logic [31:0]       perf_dm_stall_o,
  output logic [31:0]       perf_im_stall_o,
  output logic [31:0]       perf_lu_stall_o,
  output logic [31:0]       perf_flush_o
`endif
);
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, IM_WAIT = 2'd2, DM_WAIT = 2'd3} state_t;
  localparam int CW = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] WMAX = CW'(WAIT_MAX);
  state_t          state_q, state_d;
  logic            redir_pend_q, redir_pend_d;
  logic [31:0]     redir_reg_q, redir_reg_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            bus_err_q, bus_err_d;
  logic            lu_q;
  logic            boot, lu_haz, dm, br, rel, lu, im, run, br_now, redir_now;
  // Exactly one winning cause per cycle, highest priority first.
  assign boot      = state_q == BOOT;
  assign lu_haz    = bus.ID_EX_MemRead && (bus.ID_EX_Rd != 5'd0) &&
                     ((bus.ID_use_rs1 && (bus.ID_rs1 == bus.ID_EX_Rd)) ||
                      (bus.ID_use_rs2 && (bus.ID_rs2 == bus.ID_EX_Rd)));
  assign dm        = !boot && bus.DM_busy;
  assign br        = !boot && !bus.DM_busy && bus.EX_br_taken;
  assign rel       = !boot && !bus.DM_busy && !bus.EX_br_taken && redir_pend_q && !bus.IM_busy;
  assign lu        = !boot && !bus.DM_busy && !bus.EX_br_taken && !rel && lu_haz && !lu_q;
  assign im        = !boot && !bus.DM_busy && !bus.EX_br_taken && !lu && bus.IM_busy;
  assign run       = !(boot || dm || br || rel || lu || im);
  assign br_now    = br && !bus.IM_busy;
  assign redir_now = br_now || rel;
  assign bus.PC_en          = run || redir_now;
  assign bus.IF_ID_en       = run;
  assign bus.IF_ID_flush    = boot || br || rel || im;
  assign bus.ID_EX_bubble   = boot || br || lu;
  assign bus.pipe_hold      = dm;
  assign bus.redirect_valid = redir_now;
  assign bus.redirect_pc    = boot ? 32'd0 : br_now ? bus.EX_br_target : redir_reg_q;
  assign bus.bus_err        = bus_err_q;
  assign bus.ctrl_state     = state_q;
  always_comb begin
    state_d      = boot ? RUN : bus.DM_busy ? DM_WAIT : bus.IM_busy ? IM_WAIT : RUN;
    redir_pend_d = (br && bus.IM_busy) || (redir_pend_q && !redir_now);
    redir_reg_d  = (br && bus.IM_busy) ? bus.EX_br_target : redir_reg_q;
    wait_cnt_d   = !(bus.IM_busy || bus.DM_busy) ? '0 :
                   (wait_cnt_q == WMAX) ? WMAX : wait_cnt_q + 1'b1;
    bus_err_d    = bus_err_q || (wait_cnt_d == WMAX);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q      <= BOOT;
      redir_pend_q <= 1'b0;
      redir_reg_q  <= 32'd0;
      wait_cnt_q   <= '0;
      bus_err_q    <= 1'b0;
      lu_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      redir_pend_q <= redir_pend_d;
      redir_reg_q  <= redir_reg_d;
      wait_cnt_q   <= wait_cnt_d;
      bus_err_q    <= bus_err_d;
      lu_q         <= lu;
    end
`ifdef HAZ_PERF_EN
  logic [31:0] perf_dm_q, perf_im_q, perf_lu_q, perf_flush_q;
  assign perf_dm_stall_o = perf_dm_q;
  assign perf_im_stall_o = perf_im_q;
  assign perf_lu_stall_o = perf_lu_q;
  assign perf_flush_o    = perf_flush_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_dm_q    <= 32'd0;
      perf_im_q    <= 32'd0;
      perf_lu_q    <= 32'd0;
      perf_flush_q <= 32'd0;
    end else begin
      perf_dm_q    <= perf_dm_q + {31'd0, dm};
      perf_im_q    <= perf_im_q + {31'd0, im};
      perf_lu_q    <= perf_lu_q + {31'd0, lu};
      perf_flush_q <= perf_flush_q + {31'd0, br || rel};
    end
`endif
endmodule
